icache_ctrl: RTL and testbench

//  Miss/maintenance sequencer for the I-cache array. Drives the cache's lookup/refill/clear port on

---
 rtl/icache_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: I-cache miss/maintenance sequencer (lookup, burst refill, index invalidate, reset sweep).
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
`timescale 1ns/1ps
module icache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int INDEX_BITS = 7,
    localparam int OFS  = $clog2(LINE_WORDS) + 2,
    localparam int TAGW = 32 - INDEX_BITS - OFS,
    localparam int LW   = 32 * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_ack,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    input  logic                  op_req,
    input  logic [INDEX_BITS-1:0] op_index,
    output logic                  op_ack,
    output logic                  c_req,
    output logic [INDEX_BITS-1:0] c_index,
    output logic                  c_valid,
    output logic [TAGW-1:0]       c_tag,
    input  logic                  c_hit,
    input  logic [LW-1:0]         c_row,
    output logic                  c_rvalid,
    output logic [LW-1:0]         c_rdata,
    output logic                  c_clear,
    output logic [INDEX_BITS-1:0] c_clear_idx,
    output logic                  m_arvalid,
    output logic [31:0]           m_araddr,
    output logic [3:0]            m_arlen,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [31:0]           m_rdata,
    input  logic                  m_rlast
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hit,
    output logic [31:0]           perf_miss
`endif
);

    localparam int WB     = OFS - 2;
    localparam int WORD_W = 32;
    localparam int IDX_LO = OFS;
    localparam int IDX_HI = OFS + INDEX_BITS - 1;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_LOOKUP  = 3'd2,
        S_MISS_AR = 3'd3,
        S_MISS_R  = 3'd4,
        S_REFILL  = 3'd5
    } state_t;

    state_t                state_r;
    logic [INDEX_BITS-1:0] sweep_r;
    logic [WB-1:0]         beat_r;
    logic [31:OFS]         line_addr_r;
    logic [WB-1:0]         word_r;
    logic [LW-1:0]         line_r;
    logic                  m_arvalid_r;
    logic [31:0]           m_araddr_r;
    logic [3:0]            m_arlen_r;

    logic [INDEX_BITS-1:0] line_idx_s;
    logic [TAGW-1:0]       line_tag_s;
    logic                  unused_s;

    function automatic logic [31:0] pick_word(input logic [LW-1:0] row, input logic [WB-1:0] w);
        return row[w*WORD_W +: WORD_W];
    endfunction

    assign line_idx_s = line_addr_r[IDX_HI:IDX_LO];
    assign line_tag_s = line_addr_r[31:IDX_HI+1];
    assign unused_s   = ^f_addr[1:0];

    assign m_arvalid = m_arvalid_r;
    assign m_araddr  = m_araddr_r;
    assign m_arlen   = m_arlen_r;

    // Strobes and fetch response decoded from the current state and this cycle's inputs.
    always_comb begin
        f_ack       = 1'b0;
        op_ack      = 1'b0;
        c_req       = 1'b0;
        c_index     = '0;
        c_valid     = 1'b0;
        c_tag       = '0;
        c_rvalid    = 1'b0;
        c_rdata     = '0;
        c_clear     = 1'b0;
        c_clear_idx = '0;
        f_rvalid    = 1'b0;
        f_rdata     = 32'h0000_0000;
        case (state_r)
            S_INIT: begin
                c_clear     = 1'b1;
                c_clear_idx = sweep_r;
            end
            S_IDLE: begin
                // Maintenance wins over fetch so an invalidate is never starved.
                if (op_req) begin
                    c_clear     = 1'b1;
                    c_clear_idx = op_index;
                    op_ack      = 1'b1;
                end else if (f_req) begin
                    f_ack   = 1'b1;
                    c_req   = 1'b1;
                    c_index = f_addr[IDX_HI:IDX_LO];
                end else begin
                    c_req = 1'b0;
                end
            end
            S_LOOKUP: begin
                c_valid = 1'b1;
                c_index = line_idx_s;
                c_tag   = line_tag_s;
                if (c_hit) begin
                    f_rvalid = 1'b1;
                    f_rdata  = pick_word(c_row, word_r);
                end else begin
                    f_rvalid = 1'b0;
                end
            end
            S_REFILL: begin
                c_rvalid = 1'b1;
                c_index  = line_idx_s;
                c_rdata  = line_r;
                f_rvalid = 1'b1;
                f_rdata  = pick_word(line_r, word_r);
            end
            default: begin
                c_req = 1'b0;
            end
        endcase
    end

    // Sequencer state, sweep/beat counters, latched request and the registered read-address channel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_INIT;
            sweep_r     <= '0;
            beat_r      <= '0;
            line_addr_r <= '0;
            word_r      <= '0;
            line_r      <= '0;
            m_arvalid_r <= 1'b0;
            m_araddr_r  <= 32'h0000_0000;
            m_arlen_r   <= 4'h0;
        end else begin
            case (state_r)
                S_INIT: begin
                    sweep_r <= sweep_r + 1'b1;
                    if (&sweep_r) begin
                        state_r <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!op_req && f_req) begin
                        line_addr_r <= f_addr[31:OFS];
                        word_r      <= f_addr[OFS-1:2];
                        state_r     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (c_hit) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r     <= S_MISS_AR;
                        m_arvalid_r <= 1'b1;
                        m_araddr_r  <= {line_addr_r, {OFS{1'b0}}};
                        m_arlen_r   <= 4'(LINE_WORDS - 1);
                    end
                end
                S_MISS_AR: begin
                    if (m_arready) begin
                        m_arvalid_r <= 1'b0;
                        beat_r      <= '0;
                        state_r     <= S_MISS_R;
                    end
                end
                S_MISS_R: begin
                    if (m_rvalid) begin
                        line_r[beat_r*WORD_W +: WORD_W] <= m_rdata;
                        beat_r <= beat_r + 1'b1;
                        if (m_rlast) begin
                            state_r <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_r;
    logic [31:0] perf_miss_r;

    // Hit/miss tallies survive the INIT sweep; only resetn clears them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_hit_r  <= 32'h0000_0000;
            perf_miss_r <= 32'h0000_0000;
        end else if (state_r == S_LOOKUP) begin
            if (c_hit) begin
                perf_hit_r <= perf_hit_r + 32'h0000_0001;
            end else begin
                perf_miss_r <= perf_miss_r + 32'h0000_0001;
            end
        end
    end

    assign perf_hit  = perf_hit_r;
    assign perf_miss = perf_miss_r;
`endif

    icache_ctrl_chk #(
        .LINE_WORDS (LINE_WORDS),
        .WB         (WB)
    ) u_chk (
        .clk      (clk),
        .resetn   (resetn),
        .in_burst (state_r == S_MISS_R),
        .m_rvalid (m_rvalid),
        .m_rlast  (m_rlast),
        .beat     (beat_r)
    );

endmodule

// Burst protocol checks: rlast exactly on the final beat, no beats outside the data phase.
module icache_ctrl_chk #(
    parameter int LINE_WORDS = 4,
    parameter int WB         = 2
) (
    input logic          clk,
    input logic          resetn,
    input logic          in_burst,
    input logic          m_rvalid,
    input logic          m_rlast,
    input logic [WB-1:0] beat
);
    localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

    a_rlast_on_time: assert property (@(posedge clk) disable iff (!resetn)
        (in_burst && m_rvalid && m_rlast) |-> (beat == LAST_BEAT));
    a_rlast_present: assert property (@(posedge clk) disable iff (!resetn)
        (in_burst && m_rvalid && (beat == LAST_BEAT)) |-> m_rlast);
    a_no_stray_beat: assert property (@(posedge clk) disable iff (!resetn)
        m_rvalid |-> in_burst);
endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl: cache array emulator, memory responder and reference residency model.
`timescale 1ns/1ps
module tb_icache_ctrl;
    localparam int SETS = 128;
    localparam int TAGW = 21;
    localparam int LW   = 128;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic f_req, f_ack, f_rvalid, op_req, op_ack, c_req, c_valid, c_hit, c_rvalid, c_clear;
    logic [31:0] f_addr, f_rdata, m_araddr, m_rdata;
    logic [6:0] op_index, c_index, c_clear_idx;
    logic [TAGW-1:0] c_tag;
    logic [LW-1:0] c_row, c_rdata;
    logic m_arvalid, m_arready, m_rvalid, m_rlast;
    logic [3:0] m_arlen;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit, perf_miss;
`endif

    int total = 0;
    int bad = 0;
    int n_hit = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk(clk), .resetn(resetn),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .op_req(op_req), .op_index(op_index), .op_ack(op_ack),
        .c_req(c_req), .c_index(c_index), .c_valid(c_valid), .c_tag(c_tag),
        .c_hit(c_hit), .c_row(c_row), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .c_clear(c_clear), .c_clear_idx(c_clear_idx),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast)
`ifdef ICACHE_PERF_CNT_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    // Cache array emulator: tag/data store driven only by the DUT's cache port (plus a preload hook).
    logic            arr_v   [SETS];
    logic [TAGW-1:0] arr_tag [SETS];
    logic [LW-1:0]   arr_row [SETS];
    logic [6:0]      look_idx = 7'd0;
    logic [TAGW-1:0] pend_tag = '0;
    logic            pre_en = 1'b0;
    logic [LW-1:0]   pre_row;

    always @(posedge clk) begin
        if (c_req) look_idx <= c_index;
        if (c_valid) pend_tag <= c_tag;
        if (c_clear) arr_v[c_clear_idx] <= 1'b0;
        if (c_rvalid) begin
            arr_v[c_index]   <= 1'b1;
            arr_tag[c_index] <= pend_tag;
            arr_row[c_index] <= c_rdata;
        end
        if (pre_en) begin
            arr_v[0]   <= 1'b1;
            arr_tag[0] <= 21'd2;
            arr_row[0] <= pre_row;
        end
    end

    assign c_hit = c_valid && arr_v[look_idx] && (arr_tag[look_idx] == c_tag);
    assign c_row = arr_row[look_idx];

    // Reference model: which line is resident per set, and the memory contents.
    bit          ref_v   [SETS];
    int unsigned ref_tag [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h0001_0003) ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [31:0]  base;
        logic [127:0] l;
        base = a & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word(base + 32'(k*4));
        return l;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_clear_all();
        for (int s = 0; s < SETS; s++) ref_v[s] = 1'b0;
        n_hit = 0;
        n_miss = 0;
    endtask

    task automatic sweep_check(input bit preload);
        for (int i = 0; i < SETS; i++) begin
            @(negedge clk);
            check_eq("sweep_idx", {c_clear, c_clear_idx}, {1'b1, 7'(i)});
            check_eq("sweep_quiet", {f_ack, op_ack, c_req, m_arvalid}, 4'b0000);
            pre_en = preload && (i == 4);
            tick();
        end
        pre_en = 1'b0;
    endtask

    task automatic do_inval(input int unsigned idx);
        op_req = 1'b1;
        op_index = 7'(idx);
        @(negedge clk);
        check_eq("inval_ack", {op_ack, c_clear, c_clear_idx}, {2'b11, 7'(idx)});
        tick();
        op_req = 1'b0;
        ref_v[idx] = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input int ar_dly, input int max_gap, input bit op_in_burst);
        int unsigned idx, tg, waited, gap;
        bit exp_hit;
        idx = (a >> 4) % SETS;
        tg = a >> 11;
        exp_hit = ref_v[idx] && (ref_tag[idx] == tg);
        f_req = 1'b1;
        f_addr = a;
        waited = 0;
        @(negedge clk);
        while (!f_ack && waited < 300) begin
            tick();
            @(negedge clk);
            waited++;
        end
        check_eq("ack_wait", waited, 0);
        check_eq("lookup_idx", {c_req, c_index}, {1'b1, 7'(idx)});
        tick();
        f_req = 1'b0;
        f_addr = $urandom;
        @(negedge clk);
        check_eq("lookup_tag", {c_valid, c_tag}, {1'b1, 21'(tg)});
        if (exp_hit) begin
            n_hit++;
            check_eq("hit_data", {f_rvalid, f_rdata}, {1'b1, mem_word(a)});
            tick();
        end else begin
            n_miss++;
            check_eq("miss_norv", f_rvalid, 1'b0);
            tick();
            @(negedge clk);
            check_eq("ar_req", {m_arvalid, m_araddr, m_arlen}, {1'b1, a & 32'hFFFF_FFF0, 4'd3});
            for (int d = 0; d < ar_dly; d++) begin
                tick();
                @(negedge clk);
                check_eq("ar_hold", {m_arvalid, m_araddr}, {1'b1, a & 32'hFFFF_FFF0});
            end
            m_arready = 1'b1;
            tick();
            m_arready = 1'b0;
            @(negedge clk);
            check_eq("ar_drop", m_arvalid, 1'b0);
            if (op_in_burst) begin
                op_req = 1'b1;
                op_index = 7'(idx);
            end
            for (int k = 0; k < 4; k++) begin
                gap = $urandom_range(max_gap);
                for (int g = 0; g < int'(gap); g++) tick();
                m_rvalid = 1'b1;
                m_rdata = mem_word((a & 32'hFFFF_FFF0) + 32'(k*4));
                m_rlast = (k == 3);
                tick();
                m_rvalid = 1'b0;
                m_rlast = 1'b0;
                if (op_in_burst && k < 3) begin
                    @(negedge clk);
                    check_eq("op_ack_early", op_ack, 1'b0);
                end
            end
            @(negedge clk);
            check_eq("refill_wr", {c_rvalid, c_index}, {1'b1, 7'(idx)});
            check_eq("refill_line", c_rdata, mem_line(a));
            check_eq("refill_data", {f_rvalid, f_rdata, op_ack}, {1'b1, mem_word(a), 1'b0});
            tick();
            ref_v[idx] = 1'b1;
            ref_tag[idx] = tg;
            if (op_in_burst) begin
                @(negedge clk);
                check_eq("op_ack_late", {op_ack, c_clear, c_clear_idx}, {2'b11, 7'(idx)});
                tick();
                op_req = 1'b0;
                ref_v[idx] = 1'b0;
            end
        end
    endtask

    int unsigned tag_pool [3] = '{32'h100, 32'h101, 32'h3F800};
    int unsigned idx_pool [5] = '{0, 3, 5, 9, 127};

    initial begin
        logic [31:0] a;
        f_req = 1'b0; f_addr = 32'h0; op_req = 1'b0; op_index = 7'd0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rlast = 1'b0;
        pre_row = {32'h1111_1111, 32'h2222_2222, 32'h2402_0001, 32'h0BAD_F00D};
        ref_clear_all();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_clear", {c_clear, c_clear_idx}, {1'b1, 7'd0});
        check_eq("rst_quiet", {f_ack, op_ack, f_rvalid, m_arvalid, c_req, c_valid, c_rvalid}, 7'd0);
        check_eq("rst_ar", {m_araddr, m_arlen}, 36'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        f_req = 1'b1;
        f_addr = 32'h0000_1004;
        sweep_check(1'b1);
        ref_v[0] = 1'b1;
        ref_tag[0] = 2;

        // cycle 129: first IDLE cycle answers the fetch held through the sweep
        @(negedge clk);
        check_eq("first_ack", {f_ack, c_req, c_index}, {2'b11, 7'd0});
        tick();
        f_req = 1'b0;
        @(negedge clk);
        check_eq("first_hit", {f_rvalid, f_rdata}, {1'b1, 32'h2402_0001});
        n_hit++;
        tick();

        do_fetch(32'h1FC0_0018, 2, 0, 1'b0);
        do_fetch(32'h1FC0_001C, 0, 0, 1'b0);
        do_fetch(32'h0000_0050, 0, 1, 1'b0);
        do_fetch(32'h0000_0054, 0, 0, 1'b0);

        // invalidate and fetch in the same IDLE cycle: invalidate first
        op_req = 1'b1;
        op_index = 7'd5;
        f_req = 1'b1;
        f_addr = 32'h0000_0058;
        @(negedge clk);
        check_eq("op_first", {op_ack, c_clear, c_clear_idx, f_ack}, {2'b11, 7'd5, 1'b0});
        tick();
        op_req = 1'b0;
        ref_v[5] = 1'b0;
        do_fetch(32'h0000_0058, 1, 0, 1'b0);

        // invalidate raised mid-burst targets the set being refilled
        do_fetch(32'h2000_0130, 1, 1, 1'b1);
        do_fetch(32'h2000_0134, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(4) == 0) begin
                do_inval(idx_pool[$urandom_range(4)]);
            end else begin
                a = (tag_pool[$urandom_range(2)] << 11) | (idx_pool[$urandom_range(4)] << 4)
                    | ($urandom_range(3) << 2) | $urandom_range(3);
                do_fetch(a, $urandom_range(3), $urandom_range(2), 1'b0);
            end
        end

`ifdef ICACHE_PERF_CNT_EN
        @(negedge clk);
        check_eq("perf_hit", perf_hit, 32'(n_hit));
        check_eq("perf_miss", perf_miss, 32'(n_miss));
        tick();
`endif

        // async reset during beat 2 of a refill
        f_req = 1'b1;
        f_addr = 32'h3000_0208;
        @(negedge clk);
        check_eq("rb_ack", f_ack, 1'b1);
        tick();
        f_req = 1'b0;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1'b1;
            m_rdata = mem_word(32'h3000_0200 + 32'(k*4));
            tick();
        end
        m_rdata = mem_word(32'h3000_0208);
        #2;
        resetn = 1'b0;
        #1;
        m_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rb_clear", {c_clear, c_clear_idx}, {1'b1, 7'd0});
        check_eq("rb_quiet", {f_ack, op_ack, f_rvalid, m_arvalid, c_req, c_valid, c_rvalid}, 7'd0);
        check_eq("rb_ar", {m_araddr, m_arlen}, 36'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ref_clear_all();
        sweep_check(1'b0);
        do_fetch(32'h1FC0_0018, 0, 1, 1'b0);
        do_fetch(32'h1FC0_0010, 0, 0, 1'b0);

`ifdef ICACHE_PERF_CNT_EN
        @(negedge clk);
        check_eq("perf_hit_rst", perf_hit, 32'(n_hit));
        check_eq("perf_miss_rst", perf_miss, 32'(n_miss));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
